// File: rtl/data_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_bus_responder                                               |
// | Purpose : Responder for the core's data-memory port. Word RAM at the       |
// |           bottom of the address space plus a 256-byte I/O page with LEDs,  |
// |           synchronized switches, a free-running timer with compare and a   |
// |           sticky status register. Stores finish with no wait state; loads  |
// |           take one wait state.                                             |
// | Ports   : clk, reset       - clock, synchronous active-high reset          |
// |           MemRead/MemWrite - load / store strobes                          |
// |           Addr, WriteData  - byte address (word aligned), store data       |
// |           ReadData         - registered load data                          |
// |           MemReady         - access complete; core stalls while low        |
// |           Switches, Leds   - board pins                                    |
// |           TimerIrq         - level copy of STATUS.match                    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module data_bus_responder #(
  parameter int          DEPTH   = 256,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
  parameter int          LED_W   = 16,
  parameter int          SW_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             MemReady,
  input  logic [SW_W-1:0]  Switches,
  output logic [LED_W-1:0] Leds,
  output logic             TimerIrq
);

  localparam int          c_AW        = $clog2(DEPTH);
  localparam logic [32:0] c_RAM_LIMIT = 33'(DEPTH) * 33'd4;

  // Register word indices inside the I/O page (offset >> 2).
  localparam logic [5:0] c_REG_LED    = 6'd0;
  localparam logic [5:0] c_REG_SW     = 6'd1;
  localparam logic [5:0] c_REG_COUNT  = 6'd2;
  localparam logic [5:0] c_REG_CMP    = 6'd3;
  localparam logic [5:0] c_REG_STATUS = 6'd4;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RESP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      readdata_q;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [31:0]      count_q, count_d;
  logic [31:0]      cmp_q, cmp_d;
  logic             match_q, match_d;
  logic             err_q, err_d;

  logic             w_ram_hit, w_io_hit, w_unmapped;
  logic [c_AW-1:0]  w_idx;
  logic [5:0]       w_reg;
  logic             w_idle, w_wr, w_rd_start, w_err_set;
  logic             w_io_wr;
  logic [31:0]      w_led_ext, w_sw_ext, w_rdata;
  logic             w_unused_addr;

  // Byte-lane bits are ignored: all accesses are whole words.
  assign w_unused_addr = &{1'b0, Addr[1:0]};

  // ---------------- address decode ----------------
  assign w_ram_hit  = ({1'b0, Addr} < c_RAM_LIMIT);
  assign w_io_hit   = (Addr[31:8] == IO_BASE[31:8]);
  assign w_unmapped = !w_ram_hit && !w_io_hit;
  assign w_idx      = Addr[c_AW+1:2];
  assign w_reg      = Addr[7:2];

  assign w_idle     = (state_q == c_IDLE);
  // A store always wins over a simultaneous load request.
  assign w_wr       = w_idle && MemWrite;
  assign w_rd_start = w_idle && MemRead && !MemWrite;
  assign w_io_wr    = w_wr && w_io_hit;
  assign w_err_set  = w_idle && ((MemRead && MemWrite) ||
                                 ((MemRead || MemWrite) && w_unmapped));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_rd_start) state_d = c_RESP;
      c_RESP:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Only a fresh load in IDLE stalls the core; reset forces ready.
  always_comb begin
    MemReady = 1'b1;
    if (!reset && w_rd_start) MemReady = 1'b0;
  end

  // ---------------- RAM (contents not reset) ----------------
  always_ff @(posedge clk) begin
    if (w_wr && w_ram_hit) mem[w_idx] <= WriteData;
  end

  // ---------------- I/O register next-state ----------------
  always_comb begin
    // Written value is loaded as-is; counting resumes on the following edge.
    count_d = count_q + 32'd1;
    if (w_io_wr && (w_reg == c_REG_COUNT)) count_d = WriteData;

    cmp_d = cmp_q;
    if (w_io_wr && (w_reg == c_REG_CMP)) cmp_d = WriteData;

    // W1C clear applied first so a same-cycle set takes priority.
    match_d = match_q;
    err_d   = err_q;
    if (w_io_wr && (w_reg == c_REG_STATUS)) begin
      if (WriteData[0]) match_d = 1'b0;
      if (WriteData[1]) err_d   = 1'b0;
    end
    if (count_q == cmp_q) match_d = 1'b1;
    if (w_err_set)        err_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      count_q   <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (w_io_wr && (w_reg == c_REG_LED)) led_q <= WriteData[LED_W-1:0];
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
      err_q     <= err_d;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    w_led_ext              = '0;
    w_led_ext[LED_W-1:0]   = led_q;
    w_sw_ext               = '0;
    w_sw_ext[SW_W-1:0]     = sw_sync_q;
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = mem[w_idx];
    end else if (w_io_hit) begin
      case (w_reg)
        c_REG_LED:    w_rdata = w_led_ext;
        c_REG_SW:     w_rdata = w_sw_ext;
        c_REG_COUNT:  w_rdata = count_q;
        c_REG_CMP:    w_rdata = cmp_q;
        c_REG_STATUS: w_rdata = {30'd0, err_q, match_q};
        default:      w_rdata = '0;
      endcase
    end
  end

  // Load data is captured at the request edge and held until the next load.
  always_ff @(posedge clk) begin
    if (reset)           readdata_q <= '0;
    else if (w_rd_start) readdata_q <= w_rdata;
  end

  assign ReadData = readdata_q;
  assign Leds     = led_q;
  assign TimerIrq = match_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_data_bus_responder                                            |
// | Purpose : Self-checking bench for data_bus_responder: a table of store /   |
// |           load vectors with hand-computed results, plus directed sequences |
// |           for switch sync latency, timer match, unmapped access, combined  |
// |           read+write, and reset during a response.                         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_data_bus_responder;

  localparam logic [31:0] IO = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData, ReadData;
  logic        MemReady;
  logic [15:0] Switches, Leds;
  logic        TimerIrq;

  int checks = 0;
  int errors = 0;

  data_bus_responder #(
    .DEPTH(256), .IO_BASE(IO), .LED_W(16), .SW_W(16)
  ) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .Switches(Switches), .Leds(Leds), .TimerIrq(TimerIrq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    #1;
    check($sformatf("wr_ready@%h", a), {31'd0, MemReady}, 32'd1);
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    MemRead = 1'b1;
    Addr    = a;
    #1;
    check($sformatf("rd_wait@%h", a), {31'd0, MemReady}, 32'd0);
    tick();
    check($sformatf("rd_ready@%h", a), {31'd0, MemReady}, 32'd1);
    check($sformatf("rd_data@%h", a), ReadData, exp);
    tick();
    MemRead = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;   // store data, or expected load data
  } vec_t;

  vec_t vecs [$];

  initial begin
    vecs = '{
      '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF},
      '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF},
      '{1'b0, 32'h0000_0013, 32'hDEAD_BEEF},
      '{1'b1, 32'h0000_0000, 32'h1111_1111},
      '{1'b0, 32'h0000_0000, 32'h1111_1111},
      '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D},
      '{1'b0, 32'h0000_03FC, 32'hCAFE_F00D},
      '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF},
      '{1'b1, IO + 32'h0C,   32'h1234_5678},
      '{1'b0, IO + 32'h0C,   32'h1234_5678},
      '{1'b1, IO + 32'h08,   32'd100},
      '{1'b0, IO + 32'h08,   32'd100},
      '{1'b0, IO + 32'h14,   32'h0000_0000},
      '{1'b1, IO + 32'h14,   32'hFFFF_FFFF},
      '{1'b0, IO + 32'h10,   32'h0000_0000},
      '{1'b1, IO + 32'h00,   32'h0000_00A5},
      '{1'b0, IO + 32'h00,   32'h0000_00A5},
      '{1'b1, IO + 32'h00,   32'hFFFF_FFFF},
      '{1'b0, IO + 32'h00,   32'h0000_FFFF},
      '{1'b0, IO + 32'h04,   32'h0000_1234},
      '{1'b1, IO + 32'h04,   32'h0000_FFFF},
      '{1'b0, IO + 32'h04,   32'h0000_1234}
    };

    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Addr      = '0;
    WriteData = '0;
    Switches  = 16'h1234;
    repeat (3) tick();

    // Reset state
    check("rst_readdata", ReadData, 32'd0);
    check("rst_leds", {16'd0, Leds}, 32'd0);
    check("rst_irq", {31'd0, TimerIrq}, 32'd0);
    check("rst_ready", {31'd0, MemReady}, 32'd1);
    MemRead = 1'b1;
    #1;
    check("rst_ready_with_read", {31'd0, MemReady}, 32'd1);
    MemRead = 1'b0;
    tick();
    reset = 1'b0;
    do_read(IO + 32'h10, 32'd0);
    do_read(IO + 32'h0C, 32'hFFFF_FFFF);

    // Table-driven store/load vectors
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data);
        if (vecs[i].addr == IO)
          check($sformatf("leds_after_wr%0d", i), {16'd0, Leds}, vecs[i].data & 32'h0000_FFFF);
      end else begin
        do_read(vecs[i].addr, vecs[i].data);
      end
    end

    // Switch synchronizer: two-edge latency to the SW register
    Switches = 16'h5678;
    do_read(IO + 32'h04, 32'h0000_1234);
    do_read(IO + 32'h04, 32'h0000_5678);

    // Timer wrap and compare match
    do_write(IO + 32'h0C, 32'd1);
    do_write(IO + 32'h08, 32'hFFFF_FFFE);   // COUNT = FFFFFFFE after this edge
    tick();                                  // FFFFFFFF
    tick();                                  // 0
    check("irq_before_match", {31'd0, TimerIrq}, 32'd0);
    tick();                                  // 1, equals CMP
    check("irq_at_equal", {31'd0, TimerIrq}, 32'd0);
    tick();                                  // match registered
    check("irq_after_match", {31'd0, TimerIrq}, 32'd1);
    do_read(IO + 32'h10, 32'h0000_0001);
    do_write(IO + 32'h10, 32'h0000_0001);
    check("irq_cleared", {31'd0, TimerIrq}, 32'd0);
    do_read(IO + 32'h10, 32'h0000_0000);

    // Unmapped access
    do_read(32'h8000_0000, 32'd0);
    do_read(IO + 32'h10, 32'h0000_0002);
    do_write(IO + 32'h10, 32'h0000_0002);
    do_read(IO + 32'h10, 32'h0000_0000);

    // Read and write together: write lands, err set, no stall
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Addr      = 32'h0000_0020;
    WriteData = 32'hABCD_1234;
    #1;
    check("rw_both_ready", {31'd0, MemReady}, 32'd1);
    tick();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    do_read(32'h0000_0020, 32'hABCD_1234);
    do_read(IO + 32'h10, 32'h0000_0002);

    // Reset during RESP aborts the response
    MemRead = 1'b1;
    Addr    = 32'h0000_0010;
    tick();
    check("resp_ready", {31'd0, MemReady}, 32'd1);
    check("resp_data", ReadData, 32'hDEAD_BEEF);
    reset   = 1'b1;
    MemRead = 1'b0;
    tick();
    check("abort_readdata", ReadData, 32'd0);
    check("abort_ready", {31'd0, MemReady}, 32'd1);
    check("abort_leds", {16'd0, Leds}, 32'd0);
    reset = 1'b0;
    do_read(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(IO + 32'h10, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
